// File: rtl/frame_gen_pkg.sv
// Shared definitions for the frame test-pattern source: pattern encodings,
// position-tracker FSM states and the noise LFSR constants.
package frame_gen_pkg;

    typedef enum logic [2:0] {
        PAT_SOLID   = 3'd0,
        PAT_HRAMP   = 3'd1,
        PAT_VRAMP   = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_BARS    = 3'd4,
        PAT_DIAG    = 3'd5,
        PAT_LFSR    = 3'd6,
        PAT_RSVD    = 3'd7
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } trk_state_e;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left, taps on bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frame_pos_tracker.sv
// Strobe edge detection, frame/line FSM, column/row counters and timing checks
// for the frame test-pattern source.
module frame_pos_tracker
    import frame_gen_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int COL_W     = $clog2(DVAL_HIGH + 1),
    parameter int ROW_W     = $clog2(ROW_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fval_in,
    input  logic             lval_in,
    input  logic             dval_in,
    output logic [COL_W-1:0] col_cur,
    output logic [ROW_W-1:0] row_cur,
    output logic             frame_rise,
    output logic             fval_q,
    output logic             lval_q,
    output logic             dval_q,
    output logic             frame_start,
    output logic             line_start,
    output logic [15:0]      frame_count,
    output logic             err_sync,
    output logic             err_len
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(DVAL_HIGH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_COUNT);

    trk_state_e       state, state_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row, row_next;
    logic             armed;
    logic             fval_fall, lval_rise, lval_fall;
    logic             in_frame, line_end, frame_end, pix_count;
    logic             col_full, row_full;

    // armed blocks a false rise when reset releases while fval_in is already high.
    assign frame_rise = fval_in & ~fval_q & armed;
    assign fval_fall  = ~fval_in & fval_q;
    assign lval_rise  = lval_in & ~lval_q;
    assign lval_fall  = ~lval_in & lval_q;

    assign in_frame  = (state != ST_IDLE);
    assign line_end  = (state == ST_LINE) & lval_fall & ~frame_rise;
    assign frame_end = in_frame & fval_fall;
    assign pix_count = (in_frame | frame_rise) & lval_in & dval_in;

    assign col_cur  = (frame_rise | lval_rise) ? '0 : col;
    assign row_cur  = frame_rise ? '0 : row;
    assign col_full = (col_cur == COL_MAX);
    assign row_full = (row == ROW_MAX);
    // Line-end row update feeds the frame-end check in the same cycle.
    assign row_next = (line_end && !row_full) ? row + 1'b1 : row;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state;
        if (frame_rise) begin
            state_d = lval_in ? ST_LINE : ST_FRAME;
        end else begin
            case (state)
                ST_FRAME: begin
                    if (fval_fall)      state_d = ST_IDLE;
                    else if (lval_rise) state_d = ST_LINE;
                end
                ST_LINE: begin
                    if (fval_fall)      state_d = ST_IDLE;
                    else if (lval_fall) state_d = ST_FRAME;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            dval_q      <= 1'b0;
            armed       <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_count <= '0;
            err_sync    <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            state       <= state_d;
            fval_q      <= fval_in;
            lval_q      <= lval_in;
            dval_q      <= dval_in;
            armed       <= armed | ~fval_in;
            frame_start <= frame_rise;
            line_start  <= lval_rise & (in_frame | frame_rise);

            if (dval_in && !(fval_in && lval_in)) err_sync <= 1'b1;
            else if (frame_rise)                  err_sync <= 1'b0;

            if (pix_count)                     col <= col_full ? col_cur : col_cur + 1'b1;
            else if (frame_rise || lval_rise)  col <= '0;

            row <= frame_rise ? '0 : row_next;

            if (frame_end) frame_count <= frame_count + 16'd1;

            if (frame_rise) begin
                err_len <= 1'b0;
            end else if ((pix_count && col_full) ||
                         (line_end && (col_cur != COL_MAX || row_full)) ||
                         (frame_end && row_next != ROW_MAX)) begin
                err_len <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_pattern_gen.sv
// Test-pattern pixel source driven by frame timing strobes.
// Define FRAME_PATTERN_LFSR_EN to build the LFSR noise pattern (6); otherwise 6 is solid.
module frame_pattern_gen
    import frame_gen_pkg::*;
#(
    parameter int          DVAL_HIGH     = 640,
    parameter int          ROW_COUNT     = 480,
    parameter int          PIXEL_W       = 8,
    parameter int unsigned SOLID_VALUE   = 32'h80,
    parameter int          CHECKER_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fval_in,
    input  logic               lval_in,
    input  logic               dval_in,
    input  logic [2:0]         pattern_sel,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               fval_out,
    output logic               lval_out,
    output logic               dval_out,
    output logic               frame_start,
    output logic               line_start,
    output logic [15:0]        frame_count,
    output logic               err_sync,
    output logic               err_len
);

    localparam int COL_W = $clog2(DVAL_HIGH + 1);
    localparam int ROW_W = $clog2(ROW_COUNT + 1);
    localparam logic [PIXEL_W-1:0] SOLID_PIX = PIXEL_W'(SOLID_VALUE);

    function automatic logic [8*PIXEL_W-1:0] build_bar_lut();
        logic [8*PIXEL_W-1:0] lut;
        lut = '0;
        for (int b = 0; b < 8; b++) begin
            lut[b*PIXEL_W +: PIXEL_W] = PIXEL_W'((b * ((1 << PIXEL_W) - 1)) / 7);
        end
        return lut;
    endfunction

    localparam logic [8*PIXEL_W-1:0] BAR_LUT = build_bar_lut();

    logic [COL_W-1:0]   col_cur;
    logic [ROW_W-1:0]   row_cur;
    logic               frame_rise;
    logic [31:0]        col_x, row_x;
    logic [2:0]         bar_idx;
    pattern_e           pat_q, pat_cur;
    logic [PIXEL_W-1:0] pix_next;

    frame_pos_tracker #(
        .DVAL_HIGH (DVAL_HIGH),
        .ROW_COUNT (ROW_COUNT),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .fval_in     (fval_in),
        .lval_in     (lval_in),
        .dval_in     (dval_in),
        .col_cur     (col_cur),
        .row_cur     (row_cur),
        .frame_rise  (frame_rise),
        .fval_q      (fval_out),
        .lval_q      (lval_out),
        .dval_q      (dval_out),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_count (frame_count),
        .err_sync    (err_sync),
        .err_len     (err_len)
    );

    // A pixel emitted on the frame-start cycle already uses the newly selected pattern.
    assign pat_cur = frame_rise ? pattern_e'(pattern_sel) : pat_q;
    assign col_x   = 32'(col_cur);
    assign row_x   = 32'(row_cur);

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (col_x >= 32'((k * DVAL_HIGH) / 8)) bar_idx = bar_idx + 3'd1;
        end
    end

`ifdef FRAME_PATTERN_LFSR_EN
    logic [15:0] lfsr_q, lfsr_cur;

    assign lfsr_cur = frame_rise ? LFSR_SEED : lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          lfsr_q <= LFSR_SEED;
        else if (dval_in)    lfsr_q <= lfsr_step(lfsr_cur);
        else if (frame_rise) lfsr_q <= LFSR_SEED;
    end
`endif

    always_comb begin
        pix_next = SOLID_PIX;
        case (pat_cur)
            PAT_HRAMP:   pix_next = PIXEL_W'(col_x);
            PAT_VRAMP:   pix_next = PIXEL_W'(row_x);
            PAT_CHECKER: pix_next = {PIXEL_W{col_x[CHECKER_SHIFT] ^ row_x[CHECKER_SHIFT]}};
            PAT_BARS:    pix_next = BAR_LUT[32'(bar_idx)*PIXEL_W +: PIXEL_W];
            PAT_DIAG:    pix_next = PIXEL_W'(col_x + row_x + 32'(frame_count));
`ifdef FRAME_PATTERN_LFSR_EN
            PAT_LFSR:    pix_next = lfsr_cur[PIXEL_W-1:0];
`endif
            default:     pix_next = SOLID_PIX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q      <= PAT_SOLID;
            pixel_data <= '0;
        end else begin
            if (frame_rise) pat_q <= pattern_e'(pattern_sel);
            pixel_data <= dval_in ? pix_next : '0;
        end
    end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Scoreboard bench for frame_pattern_gen: drives well-formed and malformed
// frame timing, predicts each pixel, and checks strobes, pulses and error flags.
module tb_frame_pattern_gen;

    localparam int DH    = 16;
    localparam int RC    = 4;
    localparam int PW    = 8;
    localparam int CS    = 2;
    localparam int SOLID = 'h80;

    logic          clk, rst_n;
    logic          fval_in, lval_in, dval_in;
    logic [2:0]    pattern_sel;
    logic [PW-1:0] pixel_data;
    logic          fval_out, lval_out, dval_out;
    logic          frame_start, line_start;
    logic [15:0]   frame_count;
    logic          err_sync, err_len;

    frame_pattern_gen #(
        .DVAL_HIGH     (DH),
        .ROW_COUNT     (RC),
        .PIXEL_W       (PW),
        .SOLID_VALUE   (SOLID),
        .CHECKER_SHIFT (CS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fval_in     (fval_in),
        .lval_in     (lval_in),
        .dval_in     (dval_in),
        .pattern_sel (pattern_sel),
        .pixel_data  (pixel_data),
        .fval_out    (fval_out),
        .lval_out    (lval_out),
        .dval_out    (dval_out),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_count (frame_count),
        .err_sync    (err_sync),
        .err_len     (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_q[$];
    bit          mon_en = 1'b0;
    int          exp_frames = 0;
    int          cur_pat = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    logic fval_d = 0, lval_d = 0, dval_d = 0, fval_d2 = 0, lval_d2 = 0;
    always @(posedge clk) begin
        fval_d  <= fval_in;
        lval_d  <= lval_in;
        dval_d  <= dval_in;
        fval_d2 <= fval_d;
        lval_d2 <= lval_d;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic int exp_pixel(input int pat, input int c, input int r, input int fc,
                                     input logic [15:0] l);
        int b;
        case (pat)
            1: return c % 256;
            2: return r % 256;
            3: return (((c >> CS) ^ (r >> CS)) & 1) ? 255 : 0;
            4: begin
                b = 0;
                for (int k = 1; k < 8; k++) if ((k * DH) / 8 <= c) b++;
                return (b * 255) / 7;
            end
            5: return (c + r + fc) % 256;
`ifdef FRAME_PATTERN_LFSR_EN
            6: return int'(l[7:0]);
`endif
            default: return SOLID;
        endcase
    endfunction

    // Output monitor: strobe/pulse alignment and scoreboard pops.
    always @(negedge clk) begin
        if (mon_en) begin
            int e;
            vectors += 5;
            if (dval_out !== dval_d) begin miscompares++; $display("FAIL dval_out: got %b want %b", dval_out, dval_d); end
            if (fval_out !== fval_d) begin miscompares++; $display("FAIL fval_out: got %b want %b", fval_out, fval_d); end
            if (lval_out !== lval_d) begin miscompares++; $display("FAIL lval_out: got %b want %b", lval_out, lval_d); end
            if (frame_start !== (fval_d & ~fval_d2)) begin
                miscompares++; $display("FAIL frame_start: got %b want %b", frame_start, fval_d & ~fval_d2);
            end
            if (line_start !== (lval_d & ~lval_d2)) begin
                miscompares++; $display("FAIL line_start: got %b want %b", line_start, lval_d & ~lval_d2);
            end
            vectors++;
            if (dval_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL pixel unexpected: got %0h want none", pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel_data !== PW'(e)) begin
                        miscompares++; $display("FAIL pixel pat%0d: got %0h want %0h", cur_pat, pixel_data, e);
                    end
                end
            end else if (pixel_data !== '0) begin
                miscompares++; $display("FAIL idle pixel: got %0h want 0", pixel_data);
            end
        end
    end

    task automatic tick(input logic f, input logic l, input logic d);
        fval_in = f; lval_in = l; dval_in = d;
        @(posedge clk); #1;
    endtask

    task automatic pixel(input int c, input int r, input logic l);
        exp_q.push_back(exp_pixel(cur_pat, c, r, exp_frames, lfsr_m));
        tick(1'b1, l, 1'b1);
        lfsr_m = lfsr_next(lfsr_m);
    endtask

    task automatic frame_begin(input int pat);
        tick(0, 0, 0);
        pattern_sel = 3'(pat);
        cur_pat = pat;
        lfsr_m = 16'hACE1;
        tick(1, 0, 0);
        tick(1, 0, 0);
    endtask

    task automatic drive_line(input int r, input int start, input int len, input bit blank);
        for (int c = start; c < len; c++) pixel(c, r, 1'b1);
        if (blank) begin tick(1, 0, 0); tick(1, 0, 0); end
    endtask

    task automatic frame_end();
        tick(0, 0, 0);
        exp_frames++;
        tick(0, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic good_frame(input int pat);
        frame_begin(pat);
        for (int r = 0; r < RC; r++) drive_line(r, 0, DH, 1'b1);
        frame_end();
    endtask

    task automatic check_flags(input string name, input logic want_len, input logic want_sync);
        vectors += 3;
        if (err_len !== want_len) begin miscompares++; $display("FAIL %s err_len: got %b want %b", name, err_len, want_len); end
        if (err_sync !== want_sync) begin miscompares++; $display("FAIL %s err_sync: got %b want %b", name, err_sync, want_sync); end
        if (frame_count !== 16'(exp_frames)) begin
            miscompares++; $display("FAIL %s frame_count: got %0d want %0d", name, frame_count, exp_frames);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fval_in = 0; lval_in = 0; dval_in = 0; pattern_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (pixel_data !== '0) begin miscompares++; $display("FAIL reset pixel_data: got %0h want 0", pixel_data); end
        if ({fval_out, lval_out, dval_out} !== 3'b000) begin
            miscompares++; $display("FAIL reset strobes: got %b want 000", {fval_out, lval_out, dval_out});
        end
        if ({frame_start, line_start} !== 2'b00) begin
            miscompares++; $display("FAIL reset pulses: got %b want 00", {frame_start, line_start});
        end
        if ({err_len, err_sync} !== 2'b00 || frame_count !== 16'd0) begin
            miscompares++; $display("FAIL reset status: got %b/%0d want 00/0", {err_len, err_sync}, frame_count);
        end
        rst_n = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        mon_en = 1'b1;
    endtask

    task automatic test_ramp();
        good_frame(1);
        check_flags("ramp", 1'b0, 1'b0);
    endtask

    task automatic test_checker();
        good_frame(3);
        check_flags("checker", 1'b0, 1'b0);
    endtask

    task automatic test_pattern_switch();
        frame_begin(1);
        drive_line(0, 0, DH, 1'b1);
        drive_line(1, 0, DH, 1'b1);
        pattern_sel = 3'd2;
        drive_line(2, 0, DH, 1'b1);
        drive_line(3, 0, DH, 1'b1);
        frame_end();
        good_frame(2);
        check_flags("switch", 1'b0, 1'b0);
    endtask

    task automatic test_bars_diag();
        good_frame(4);
        good_frame(5);
        good_frame(7);
        check_flags("bars_diag", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // last line ends on the same cycle fval falls
        frame_begin(1);
        for (int r = 0; r < RC - 1; r++) drive_line(r, 0, DH, 1'b1);
        drive_line(RC - 1, 0, DH, 1'b0);
        frame_end();
        check_flags("simul_fall", 1'b0, 1'b0);
    endtask

    task automatic test_len_error();
        frame_begin(0);
        drive_line(0, 0, DH, 1'b1);
        drive_line(1, 0, DH - 1, 1'b1);
        vectors++;
        if (err_len !== 1'b1) begin miscompares++; $display("FAIL short_line err_len: got %b want 1", err_len); end
        drive_line(2, 0, DH, 1'b1);
        drive_line(3, 0, DH, 1'b1);
        frame_end();
        check_flags("short_line_end", 1'b1, 1'b0);
        frame_begin(0);
        vectors++;
        if (err_len !== 1'b0) begin miscompares++; $display("FAIL len_clear err_len: got %b want 0", err_len); end
        frame_end();
        check_flags("zero_lines", 1'b1, 1'b0);
        frame_begin(0);
        drive_line(0, 0, DH + 1, 1'b1);
        vectors++;
        if (err_len !== 1'b1) begin miscompares++; $display("FAIL long_line err_len: got %b want 1", err_len); end
        for (int r = 1; r < RC; r++) drive_line(r, 0, DH, 1'b1);
        frame_end();
        frame_begin(0);
        for (int r = 0; r < RC + 1; r++) drive_line(r, 0, DH, 1'b1);
        frame_end();
        check_flags("extra_line", 1'b1, 1'b0);
        good_frame(1);
        check_flags("len_recover", 1'b0, 1'b0);
    endtask

    task automatic test_sync_error();
        frame_begin(0);
        exp_q.push_back(SOLID);
        tick(1, 0, 1);
        lfsr_m = lfsr_next(lfsr_m);
        vectors++;
        if (err_sync !== 1'b1) begin miscompares++; $display("FAIL stray_dval err_sync: got %b want 1", err_sync); end
        tick(1, 0, 0);
        for (int r = 0; r < RC; r++) drive_line(r, 0, DH, 1'b1);
        frame_end();
        check_flags("sync_sticky", 1'b0, 1'b1);
        frame_begin(0);
        vectors++;
        if (err_sync !== 1'b0) begin miscompares++; $display("FAIL sync_clear err_sync: got %b want 0", err_sync); end
        for (int r = 0; r < RC; r++) drive_line(r, 0, DH, 1'b1);
        frame_end();
        exp_q.push_back(SOLID);
        tick(0, 0, 1);
        lfsr_m = lfsr_next(lfsr_m);
        vectors++;
        if (err_sync !== 1'b1) begin miscompares++; $display("FAIL idle_dval err_sync: got %b want 1", err_sync); end
        tick(0, 0, 0);
        good_frame(2);
        check_flags("sync_recover", 1'b0, 1'b0);
    endtask

    task automatic test_lfsr();
        int first;
`ifdef FRAME_PATTERN_LFSR_EN
        first = 'hE1;
`else
        first = SOLID;
`endif
        for (int f = 0; f < 2; f++) begin
            frame_begin(6);
            pixel(0, 0, 1'b1);
            vectors++;
            if (pixel_data !== PW'(first)) begin
                miscompares++; $display("FAIL lfsr_first f%0d: got %0h want %0h", f, pixel_data, first);
            end
            drive_line(0, 1, DH, 1'b1);
            for (int r = 1; r < RC; r++) drive_line(r, 0, DH, 1'b1);
            frame_end();
        end
        check_flags("lfsr", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        mon_en = 1'b0;
        frame_begin(1);
        for (int c = 0; c < 5; c++) tick(1, 1, 1);
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (frame_count !== 16'd0 || pixel_data !== '0) begin
            miscompares++; $display("FAIL midreset outputs: got %0d/%0h want 0/0", frame_count, pixel_data);
        end
        if ({fval_out, dval_out, err_len, err_sync} !== 4'b0000) begin
            miscompares++; $display("FAIL midreset flags: got %b want 0000", {fval_out, dval_out, err_len, err_sync});
        end
        tick(1, 1, 1);
        tick(1, 1, 1);
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) tick(1, 1, 1);
        tick(1, 0, 0); tick(1, 0, 0);
        for (int c = 0; c < DH; c++) tick(1, 1, 1);
        tick(1, 0, 0);
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        exp_q.delete();
        exp_frames = 0;
        check_flags("partial_ignored", 1'b0, 1'b0);
        mon_en = 1'b1;
        good_frame(2);
        check_flags("after_midreset", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_checker();
        test_pattern_switch();
        test_bars_diag();
        test_back_to_back();
        test_len_error();
        test_sync_error();
        test_lfsr();
        test_reset_mid_frame();
        tick(0, 0, 0);
        tick(0, 0, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
